// File: rtl/vmem_wr_ctrl.sv
// CPU-side writer for the LCD video-memory word.
// Double-buffered: stores land in a back buffer that is copied to the front on vsync after a commit.
module vmem_wr_ctrl #(
    parameter int                 DATA_W         = 64,
    parameter logic [DATA_W-1:0]  RST_PATTERN    = '0,
    parameter bit                 VS_ACTIVE_HIGH = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [1:0]            wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    input  logic                  rd_valid,
    input  logic [1:0]            rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  vsync,
    output logic [DATA_W-1:0]     vmem_data,
    output logic                  swap_pulse
);

    localparam int   STRB_W  = DATA_W / 8;
    localparam logic VS_IDLE = !VS_ACTIVE_HIGH;

    localparam logic [1:0] A_BACK   = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_FRAME  = 2'd3;

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  back;
    logic [31:0]        frame_cnt;

    logic               vs_s1;
    logic               vs_s2;
    logic               vs_s3;
    logic               vs_act;
    logic               vs_edge;

    logic               wr_fire;
    logic               back_wr;
    logic               commit;
    logic [DATA_W-1:0]  rd_mux;

    // Two-flop synchronizer plus one delay flop for edge detection.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vs_s1 <= VS_IDLE;
            vs_s2 <= VS_IDLE;
            vs_s3 <= VS_IDLE;
        end else begin
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    assign vs_act = VS_ACTIVE_HIGH ? (vs_s2 && !vs_s3)
                                   : (!vs_s2 && vs_s3);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vs_edge <= 1'b0;
        end else begin
            vs_edge <= vs_act;
        end
    end

    // STATUS/FRAME_CNT stores are always accepted (and dropped).
    assign wr_ready = (state == IDLE) || wr_addr[1];
    assign wr_fire  = wr_valid && wr_ready;
    assign back_wr  = wr_fire && (wr_addr == A_BACK);
    assign commit   = wr_fire && (wr_addr == A_CTRL)
                      && wr_strb[0] && wr_data[0];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            back <= RST_PATTERN;
        end else if (back_wr) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) begin
                    back[i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // A commit taken alongside a vs_edge waits for the following edge,
    // since the swap only fires from PENDING.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            vmem_data  <= RST_PATTERN;
            swap_pulse <= 1'b0;
        end else begin
            swap_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (commit) begin
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (vs_edge) begin
                        vmem_data  <= back;
                        swap_pulse <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_cnt <= '0;
        end else if (vs_edge) begin
            frame_cnt <= frame_cnt + 32'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (rd_addr)
            A_BACK:   rd_mux = back;
            A_CTRL:   rd_mux = '0;
            A_STATUS: begin
                rd_mux[0] = (state == PENDING);
                rd_mux[1] = vs_s2;
            end
            A_FRAME:  rd_mux = DATA_W'(frame_cnt);
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_data <= '0;
        end else if (rd_valid) begin
            rd_data <= rd_mux;
        end
    end

endmodule
